// File: rtl/pepinos_clock_shuffle.sv
// Clock dividers (25 MHz pixel clock, 1 Hz cursor clock) and an LFSR-driven
// Fisher-Yates shuffle of 20 card slots, re-runnable on request.
module pepinos_clock_shuffle #(
  parameter int unsigned HALF_PERIOD_1HZ = 25_000_000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic         clock_50M,
  input  logic         reset_n,
  input  logic         shuffle_req,
  output logic         clock_25M,
  output logic         clock_1Hz,
  output logic [99:0]  card_order,
  output logic         order_valid
);

  localparam int unsigned CNT_W = (HALF_PERIOD_1HZ > 1) ? $clog2(HALF_PERIOD_1HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD_1HZ - 1);
  // An all-zero Fibonacci LFSR would lock up, so substitute a non-zero seed.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int unsigned N_CARDS = 20;
  localparam logic [4:0] IDX_TOP = 5'd19;
  localparam logic [4:0] UNASSIGNED = 5'd31;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SHUFFLE,
    ST_DONE
  } state_t;

  logic             clock_25M_reg;
  logic             clock_1Hz_reg;
  logic [CNT_W-1:0] count_reg;

  logic [15:0]      lfsr_reg;
  logic [15:0]      lfsr_next;
  logic             lfsr_fb;

  state_t           state_reg;
  state_t           state_next;
  logic [4:0]       idx_reg;
  logic [4:0]       idx_next;
  logic             valid_reg;
  logic             valid_next;
  logic             load_identity;
  logic             do_swap;

  logic [4:0]       entry_reg  [N_CARDS];
  logic [4:0]       entry_next [N_CARDS];
  logic [4:0]       entry_at_i;
  logic [4:0]       entry_at_r;

  logic [4:0]       idx_plus1;
  logic [12:0]      product;
  logic [4:0]       rnd_idx;

  // Clock dividers.
  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      clock_25M_reg <= 1'b0;
    end else begin
      clock_25M_reg <= ~clock_25M_reg;
    end
  end

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      count_reg     <= '0;
      clock_1Hz_reg <= 1'b0;
    end else if (count_reg == CNT_LAST) begin
      count_reg     <= '0;
      clock_1Hz_reg <= ~clock_1Hz_reg;
    end else begin
      count_reg     <= count_reg + CNT_W'(1);
    end
  end

  assign clock_25M = clock_25M_reg;
  assign clock_1Hz = clock_1Hz_reg;

  // Free-running LFSR; it keeps advancing in every state so each reshuffle
  // draws from a different part of the sequence.
  assign lfsr_fb   = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign lfsr_next = {lfsr_reg[14:0], lfsr_fb};

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_reg <= SEED_EFF;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  // Scale an 8-bit random fraction into 0..i without a divider.
  assign idx_plus1 = idx_reg + 5'd1;
  assign product   = {5'd0, lfsr_reg[7:0]} * {8'd0, idx_plus1};
  assign rnd_idx   = product[12:8];

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    valid_next    = valid_reg;
    load_identity = 1'b0;
    do_swap       = 1'b0;
    case (state_reg)
      ST_INIT: begin
        load_identity = 1'b1;
        idx_next      = IDX_TOP;
        valid_next    = 1'b0;
        state_next    = ST_SHUFFLE;
      end
      ST_SHUFFLE: begin
        do_swap  = 1'b1;
        idx_next = idx_reg - 5'd1;
        if (idx_reg == 5'd1) begin
          state_next = ST_DONE;
          valid_next = 1'b1;
        end
      end
      ST_DONE: begin
        if (shuffle_req) begin
          idx_next   = IDX_TOP;
          valid_next = 1'b0;
          state_next = ST_SHUFFLE;
        end
      end
      default: begin
        state_next = ST_INIT;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_INIT;
      idx_reg   <= IDX_TOP;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
    end
  end

  assign order_valid = valid_reg;

  // Read ports for the two swap operands.
  always_comb begin
    entry_at_i = UNASSIGNED;
    entry_at_r = UNASSIGNED;
    for (int k = 0; k < N_CARDS; k++) begin
      if (idx_reg == 5'(k)) begin
        entry_at_i = entry_reg[k];
      end
      if (rnd_idx == 5'(k)) begin
        entry_at_r = entry_reg[k];
      end
    end
  end

  // Slot i takes slot r's value first, so r == i naturally degenerates to a hold.
  generate
    for (genvar gi = 0; gi < N_CARDS; gi++) begin : g_entry
      assign entry_next[gi] =
          load_identity                       ? 5'(gi)     :
          (do_swap && (idx_reg == 5'(gi)))    ? entry_at_r :
          (do_swap && (rnd_idx == 5'(gi)))    ? entry_at_i :
                                                entry_reg[gi];
      assign card_order[5*gi +: 5] = entry_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_CARDS; k++) begin
        entry_reg[k] <= UNASSIGNED;
      end
    end else begin
      for (int k = 0; k < N_CARDS; k++) begin
        entry_reg[k] <= entry_next[k];
      end
    end
  end

endmodule

// File: tb/tb_pepinos_clock_shuffle.sv
// Bench for pepinos_clock_shuffle: table-driven clock/valid checks plus a
// scoreboard of model-predicted card orders popped when each shuffle completes.
`timescale 1ns/1ps
module tb_pepinos_clock_shuffle;

  localparam logic [15:0] SEED_A = 16'hACE1;
  localparam logic [15:0] SEED_B = 16'h0000;

  logic        clock_50M = 1'b0;
  logic        reset_n;
  logic        shuffle_req;
  logic        clock_25M, clock_1Hz, order_valid;
  logic [99:0] card_order;
  logic        b_25M, b_1Hz, b_valid;
  logic [99:0] b_order;

  always #10 clock_50M = ~clock_50M;

  pepinos_clock_shuffle #(.HALF_PERIOD_1HZ(4), .LFSR_SEED(SEED_A)) dut (
    .clock_50M  (clock_50M),
    .reset_n    (reset_n),
    .shuffle_req(shuffle_req),
    .clock_25M  (clock_25M),
    .clock_1Hz  (clock_1Hz),
    .card_order (card_order),
    .order_valid(order_valid)
  );

  pepinos_clock_shuffle #(.HALF_PERIOD_1HZ(4), .LFSR_SEED(SEED_B)) dut_b (
    .clock_50M  (clock_50M),
    .reset_n    (reset_n),
    .shuffle_req(1'b0),
    .clock_25M  (b_25M),
    .clock_1Hz  (b_1Hz),
    .card_order (b_order),
    .order_valid(b_valid)
  );

  typedef struct {
    int   edge_no;
    logic c25;
    logic c1;
    logic valid;
  } vec_t;

  vec_t        vecs[15];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_n = 0;
  logic [99:0] exp_q[$];
  logic [99:0] all31;
  logic [99:0] p1, p2, held;

  function automatic logic [15:0] adv(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [99:0] identity();
    logic [99:0] v;
    for (int k = 0; k < 20; k++) v[5*k +: 5] = 5'(k);
    return v;
  endfunction

  // Reference Fisher-Yates: n_adv is how many LFSR steps precede the first swap.
  function automatic logic [99:0] model_shuffle(input logic [99:0] start,
                                                input logic [15:0] seed,
                                                input int n_adv);
    logic [4:0]  e[20];
    logic [4:0]  t;
    logic [15:0] l;
    logic [99:0] v;
    int          r;
    for (int k = 0; k < 20; k++) e[k] = start[5*k +: 5];
    l = (seed == 16'h0000) ? 16'h0001 : seed;
    repeat (n_adv) l = adv(l);
    for (int i = 19; i >= 1; i--) begin
      r    = (int'(l[7:0]) * (i + 1)) / 256;
      t    = e[i];
      e[i] = e[r];
      e[r] = t;
      l    = adv(l);
    end
    for (int k = 0; k < 20; k++) v[5*k +: 5] = e[k];
    return v;
  endfunction

  function automatic logic is_perm(input logic [99:0] v);
    int seen[20];
    for (int k = 0; k < 20; k++) seen[k] = 0;
    for (int k = 0; k < 20; k++) begin
      if (v[5*k +: 5] > 5'd19) return 1'b0;
      seen[v[5*k +: 5]]++;
    end
    for (int k = 0; k < 20; k++) if (seen[k] != 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [99:0] act, input logic [99:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h want %h", name, edge_n, act, exp);
    end else begin
      $display("ok   %s @edge %0d: %h", name, edge_n, act);
    end
  endtask

  task automatic tick();
    @(posedge clock_50M);
    #1;
    edge_n++;
  endtask

  task automatic pop_check(input string name, output logic [99:0] got);
    got = '0;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, got %h want queued entry", name, card_order);
    end else begin
      got = exp_q.pop_front();
      if (card_order !== got) begin
        n_bad++;
        $display("FAIL %s @edge %0d: got %h want %h", name, edge_n, card_order, got);
      end else begin
        $display("ok   %s @edge %0d: %h", name, edge_n, card_order);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{0,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1,  1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3,  1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4,  1'b0, 1'b1, 1'b0};
    vecs[5]  = '{5,  1'b1, 1'b1, 1'b0};
    vecs[6]  = '{7,  1'b1, 1'b1, 1'b0};
    vecs[7]  = '{8,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{9,  1'b1, 1'b0, 1'b0};
    vecs[9]  = '{12, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{16, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{19, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{20, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{21, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{24, 1'b0, 1'b0, 1'b1};
    all31 = {20{5'd31}};
    p1 = '0;
    p2 = '0;

    // Reset held with the clock running.
    reset_n     = 1'b0;
    shuffle_req = 1'b0;
    repeat (3) @(posedge clock_50M);
    #1;
    chk("rst_c25", clock_25M, 1'b0);
    chk("rst_c1", clock_1Hz, 1'b0);
    chk("rst_valid", order_valid, 1'b0);
    chk("rst_cards", card_order, all31);

    // First shuffle; shuffle_req held high through INIT and early SHUFFLE.
    @(negedge clock_50M);
    reset_n     = 1'b1;
    shuffle_req = 1'b1;
    edge_n      = 0;
    exp_q.push_back(model_shuffle(identity(), SEED_A, 1));
    for (int v = 0; v < 15; v++) begin
      while (edge_n < vecs[v].edge_no) begin
        tick();
        if (edge_n == 10) shuffle_req = 1'b0;
        if (edge_n == 1 || edge_n == 6 || edge_n == 13) chk("perm_mid", is_perm(card_order), 1'b1);
      end
      chk("c25", clock_25M, vecs[v].c25);
      chk("c1", clock_1Hz, vecs[v].c1);
      chk("valid", order_valid, vecs[v].valid);
      if (vecs[v].edge_no == 20) begin
        pop_check("order_a", p1);
        chk("perm_a", is_perm(card_order), 1'b1);
        chk("order_b", b_order, model_shuffle(identity(), SEED_B, 1));
        chk("valid_b", b_valid, 1'b1);
        chk("seed_differs", (card_order != b_order), 1'b1);
      end
    end

    // Requested reshuffle from DONE, starting from the current order.
    shuffle_req = 1'b1;
    tick();
    shuffle_req = 1'b0;
    exp_q.push_back(model_shuffle(p1, SEED_A, edge_n));
    chk("reshuf_low", order_valid, 1'b0);
    for (int j = 1; j < 19; j++) begin
      tick();
      if (j == 9 || j == 18) chk("reshuf_low", order_valid, 1'b0);
    end
    tick();
    chk("reshuf_high", order_valid, 1'b1);
    pop_check("order_reshuf", p2);
    chk("perm_reshuf", is_perm(card_order), 1'b1);

    // DONE holds its order while no request arrives.
    held = card_order;
    repeat (4) tick();
    chk("done_hold", card_order, held);
    chk("done_valid", order_valid, 1'b1);

    // Reset mid-shuffle (SHUFFLE cycle 7), then a full restart.
    reset_n = 1'b0;
    #2;
    @(negedge clock_50M);
    reset_n = 1'b1;
    edge_n  = 0;
    repeat (8) tick();
    chk("pre_abort_valid", order_valid, 1'b0);
    reset_n = 1'b0;
    #2;
    chk("abort_cards", card_order, all31);
    chk("abort_valid", order_valid, 1'b0);
    chk("abort_c25", clock_25M, 1'b0);
    @(negedge clock_50M);
    reset_n = 1'b1;
    edge_n  = 0;
    exp_q.push_back(model_shuffle(identity(), SEED_A, 1));
    repeat (19) tick();
    chk("restart_low", order_valid, 1'b0);
    tick();
    chk("restart_high", order_valid, 1'b1);
    pop_check("order_restart", held);
    chk("restart_same", card_order, p1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
